// File: rtl/ram_port_responder_if.sv
// Data-RAM port bundle between the core's registered RAM port and the
// memory-side responder, plus the responder's error and counter outputs.
interface ram_port_responder_if;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wen;
    logic        ram_ren;
    logic [31:0] ram_rdata;
    logic        ram_rvalid;
    logic        err_flag;
    logic [31:0] err_addr;
    logic        err_clear;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    // Core side: drives requests and the error clear, observes responses.
    modport master (
        output ram_addr, ram_wdata, ram_wen, ram_ren, err_clear,
        input  ram_rdata, ram_rvalid, err_flag, err_addr, rd_count, wr_count
    );

    // Memory side: services requests and reports status.
    modport slave (
        input  ram_addr, ram_wdata, ram_wen, ram_ren, err_clear,
        output ram_rdata, ram_rvalid, err_flag, err_addr, rd_count, wr_count
    );
endinterface

// File: rtl/ram_port_responder.sv
// Memory-side responder for the core's data-RAM port: byte-enabled word
// storage, fixed read latency, out-of-range detection with a sticky first-
// error record, and saturating read/write access counters.
module ram_port_responder #(
    parameter int          ADDR_WIDTH   = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 2
) (
    input logic               clk,
    input logic               srst,
    ram_port_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_stageValid;
    logic [31:0]           r_stageData [READ_LATENCY];
    logic [31:0]           r_rdataHold;
    logic                  r_errFlag;
    logic [31:0]           r_errAddr;
    logic [15:0]           r_rdCount;
    logic [15:0]           r_wrCount;

    logic                  w_inRange;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_anyWrite;
    logic                  w_doWrite;
    logic                  w_errEvent;
    logic [31:0]           w_mergedWord;
    logic [31:0]           w_readWord;
    logic                  w_unusedAddrLow;

    assign w_inRange  = (bus.ram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_index    = bus.ram_addr[ADDR_WIDTH+1:2];
    assign w_anyWrite = |bus.ram_wen;
    assign w_doWrite  = w_inRange && w_anyWrite;
    assign w_errEvent = !w_inRange && (bus.ram_ren || w_anyWrite);
    // Byte offset within a word carries no meaning for a word-wide port.
    assign w_unusedAddrLow = ^bus.ram_addr[1:0];

    // Post-write view of the addressed word, so a same-cycle read sees the write.
    always_comb begin
        w_mergedWord = r_mem[w_index];
        for (int i = 0; i < 4; i++) begin
            if (bus.ram_wen[i]) begin
                w_mergedWord[8*i +: 8] = bus.ram_wdata[8*i +: 8];
            end
        end
    end

    assign w_readWord = w_inRange ? w_mergedWord : 32'h0000_0000;

    // Byte-lane storage update; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!srst && w_doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ram_wen[i]) begin
                    r_mem[w_index][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read shift chain: every request enters stage 0 and emerges READ_LATENCY edges later.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_stageValid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_stageData[i] <= 32'h0000_0000;
            end
        end else begin
            r_stageValid[0] <= bus.ram_ren;
            r_stageData[0]  <= w_readWord;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_stageValid[i] <= r_stageValid[i-1];
                r_stageData[i]  <= r_stageData[i-1];
            end
        end
    end

    // Remember the last delivered word so ram_rdata holds between completions.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_rdataHold <= 32'h0000_0000;
        end else if (r_stageValid[READ_LATENCY-1]) begin
            r_rdataHold <= r_stageData[READ_LATENCY-1];
        end
    end

    // Sticky first-error capture; a clear in the same cycle beats a new error.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_errFlag <= 1'b0;
            r_errAddr <= 32'h0000_0000;
        end else if (bus.err_clear) begin
            r_errFlag <= 1'b0;
            r_errAddr <= 32'h0000_0000;
        end else if (w_errEvent && !r_errFlag) begin
            r_errFlag <= 1'b1;
            r_errAddr <= bus.ram_addr;
        end
    end

    // Saturating counters of accepted in-range reads and write cycles.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_rdCount <= 16'h0000;
            r_wrCount <= 16'h0000;
        end else begin
            if (bus.ram_ren && w_inRange && (r_rdCount != 16'hFFFF)) begin
                r_rdCount <= r_rdCount + 16'd1;
            end
            if (w_doWrite && (r_wrCount != 16'hFFFF)) begin
                r_wrCount <= r_wrCount + 16'd1;
            end
        end
    end

    assign bus.ram_rvalid = r_stageValid[READ_LATENCY-1];
    assign bus.ram_rdata  = r_stageValid[READ_LATENCY-1] ? r_stageData[READ_LATENCY-1] : r_rdataHold;
    assign bus.err_flag   = r_errFlag;
    assign bus.err_addr   = r_errAddr;
    assign bus.rd_count   = r_rdCount;
    assign bus.wr_count   = r_wrCount;
endmodule

// File: tb/tb_ram_port_responder.sv
// Testbench for ram_port_responder: three instances (latency 1, 2, 4) share
// one stimulus stream and are compared every cycle against a behavioural
// model, with a few literal checks of the headline scenarios on top.
module tb_ram_port_responder;
    logic        clk = 1'b0;
    logic        srst;
    logic [31:0] tbAddr;
    logic [31:0] tbWdata;
    logic [3:0]  tbWen;
    logic        tbRen;
    logic        tbClr;

    int checks   = 0;
    int failures = 0;

    // Clock generation, 10 time-unit period.
    always #5 clk = ~clk;

    ram_port_responder_if bus1 ();
    ram_port_responder_if bus2 ();
    ram_port_responder_if bus4 ();

    assign bus1.ram_addr  = tbAddr;
    assign bus1.ram_wdata = tbWdata;
    assign bus1.ram_wen   = tbWen;
    assign bus1.ram_ren   = tbRen;
    assign bus1.err_clear = tbClr;
    assign bus2.ram_addr  = tbAddr;
    assign bus2.ram_wdata = tbWdata;
    assign bus2.ram_wen   = tbWen;
    assign bus2.ram_ren   = tbRen;
    assign bus2.err_clear = tbClr;
    assign bus4.ram_addr  = tbAddr;
    assign bus4.ram_wdata = tbWdata;
    assign bus4.ram_wen   = tbWen;
    assign bus4.ram_ren   = tbRen;
    assign bus4.err_clear = tbClr;

    ram_port_responder #(.READ_LATENCY(1)) dut1 (.clk(clk), .srst(srst), .bus(bus1.slave));
    ram_port_responder #(.READ_LATENCY(2)) dut2 (.clk(clk), .srst(srst), .bus(bus2.slave));
    ram_port_responder #(.READ_LATENCY(4)) dut4 (.clk(clk), .srst(srst), .bus(bus4.slave));

    // Behavioural model: word array, completions scheduled by cycle number.
    logic [31:0] mdlMem [4096];
    int          lat [3] = '{1, 2, 4};
    bit          schedV [3][8];
    logic [31:0] schedD [3][8];
    logic        expRvalid [3];
    logic [31:0] expRdata [3];
    logic        expErr;
    logic [31:0] expErrAddr;
    int          expRd;
    int          expWr;
    int          cyc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic updateModel();
        logic        inR;
        logic [11:0] idx;
        logic [31:0] rw;
        int          slot;
        cyc++;
        if (srst) begin
            for (int d = 0; d < 3; d++) begin
                for (int s = 0; s < 8; s++) schedV[d][s] = 1'b0;
                expRvalid[d] = 1'b0;
                expRdata[d]  = 32'h0;
            end
            expErr = 1'b0;
            expErrAddr = 32'h0;
            expRd = 0;
            expWr = 0;
        end else begin
            inR = (tbAddr < 32'h0000_4000);
            idx = tbAddr[13:2];
            if (inR && tbWen != 4'h0) begin
                for (int l = 0; l < 4; l++) begin
                    if (tbWen[l]) mdlMem[idx][8*l +: 8] = tbWdata[8*l +: 8];
                end
                if (expWr < 65535) expWr++;
            end
            if (tbRen) begin
                rw = inR ? mdlMem[idx] : 32'h0;
                for (int d = 0; d < 3; d++) begin
                    slot = (cyc + lat[d] - 1) % 8;
                    schedV[d][slot] = 1'b1;
                    schedD[d][slot] = rw;
                end
                if (inR && expRd < 65535) expRd++;
            end
            if (tbClr) begin
                expErr = 1'b0;
                expErrAddr = 32'h0;
            end else if (!inR && (tbRen || tbWen != 4'h0) && !expErr) begin
                expErr = 1'b1;
                expErrAddr = tbAddr;
            end
            for (int d = 0; d < 3; d++) begin
                slot = cyc % 8;
                if (schedV[d][slot]) begin
                    expRvalid[d] = 1'b1;
                    expRdata[d]  = schedD[d][slot];
                    schedV[d][slot] = 1'b0;
                end else begin
                    expRvalid[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOne(input string nm, input int d, input logic [31:0] rdata, input logic rvalid,
                            input logic ef, input logic [31:0] ea, input logic [15:0] rc, input logic [15:0] wc);
        checkOutput({nm, "_rvalid"}, 32'(rvalid), 32'(expRvalid[d]));
        checkOutput({nm, "_rdata"}, rdata, expRdata[d]);
        checkOutput({nm, "_err_flag"}, 32'(ef), 32'(expErr));
        checkOutput({nm, "_err_addr"}, ea, expErrAddr);
        checkOutput({nm, "_rd_count"}, 32'(rc), expRd);
        checkOutput({nm, "_wr_count"}, 32'(wc), expWr);
    endtask

    task automatic checkAll();
        checkOne("L1", 0, bus1.ram_rdata, bus1.ram_rvalid, bus1.err_flag, bus1.err_addr, bus1.rd_count, bus1.wr_count);
        checkOne("L2", 1, bus2.ram_rdata, bus2.ram_rvalid, bus2.err_flag, bus2.err_addr, bus2.rd_count, bus2.wr_count);
        checkOne("L4", 2, bus4.ram_rdata, bus4.ram_rvalid, bus4.err_flag, bus4.err_addr, bus4.rd_count, bus4.wr_count);
    endtask

    // Drive one cycle of inputs, advance past the edge, then compare everything.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen,
                                 input logic ren, input logic clr, input logic rst);
        tbAddr  = addr;
        tbWdata = wdata;
        tbWen   = wen;
        tbRen   = ren;
        tbClr   = clr;
        srst    = rst;
        @(posedge clk);
        updateModel();
        #2;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc = 0;
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 8; s++) begin
                schedV[d][s] = 1'b0;
                schedD[d][s] = 32'h0;
            end
        end
        tbAddr = 32'h0; tbWdata = 32'h0; tbWen = 4'h0; tbRen = 1'b0; tbClr = 1'b0; srst = 1'b1;

        $display("[TB] reset and idle");
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_rdata", bus2.ram_rdata, 32'h0);
        checkOutput("rst_rvalid", 32'(bus2.ram_rvalid), 32'h0);
        checkOutput("rst_err_flag", 32'(bus2.err_flag), 32'h0);
        checkOutput("rst_rd_count", 32'(bus2.rd_count), 32'h0);
        checkOutput("rst_wr_count", 32'(bus2.wr_count), 32'h0);
        idle(10);

        $display("[TB] preload words 0..63, then reset (storage kept)");
        for (int i = 0; i < 64; i++) applyStimulus(32'(i * 4), 32'(i), 4'hF, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        $display("[TB] byte-lane merge");
        applyStimulus(32'h40, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h40, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("merge_rdata", bus2.ram_rdata, 32'h11BB_33DD);
        checkOutput("merge_rvalid", 32'(bus2.ram_rvalid), 32'h1);
        idle(1);
        checkOutput("merge_rvalid_single", 32'(bus2.ram_rvalid), 32'h0);
        checkOutput("merge_wr_count", 32'(bus2.wr_count), 32'h2);
        checkOutput("merge_rd_count", 32'(bus2.rd_count), 32'h1);
        idle(2);

        $display("[TB] write-first collision");
        applyStimulus(32'h80, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("collide_rdata", bus2.ram_rdata, 32'hCAFE_F00D);
        idle(3);

        $display("[TB] pipelined reads");
        for (int i = 0; i < 4; i++) applyStimulus(32'(i * 4), 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("pipe_last_rdata", bus2.ram_rdata, 32'h3);
        idle(3);

        $display("[TB] out-of-range accesses");
        applyStimulus(32'h0001_0000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0002_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b0);
        checkOutput("oor_rdata", bus2.ram_rdata, 32'h0);
        idle(1);
        checkOutput("oor_err_flag", 32'(bus2.err_flag), 32'h1);
        checkOutput("oor_err_addr", bus2.err_addr, 32'h0001_0000);
        checkOutput("oor_rd_count", 32'(bus2.rd_count), 32'h6);
        checkOutput("oor_wr_count", 32'(bus2.wr_count), 32'h3);
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("oor_no_alias", bus2.ram_rdata, 32'h0);
        idle(2);
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_err_flag", 32'(bus2.err_flag), 32'h0);
        checkOutput("clr_err_addr", bus2.err_addr, 32'h0);

        $display("[TB] reset mid-read");
        applyStimulus(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_rvalid", 32'(bus2.ram_rvalid), 32'h0);
        checkOutput("midrst_rdata", bus2.ram_rdata, 32'h0);
        idle(1);
        checkOutput("midrst_rvalid_after", 32'(bus2.ram_rvalid), 32'h0);
        applyStimulus(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("midrst_kept_word", bus2.ram_rdata, 32'h11BB_33DD);
        idle(3);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = {16'($urandom_range(1, 65535)), 16'($urandom)};
            else a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
            applyStimulus(a, $urandom,
                          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 49) == 0));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
